// File: rtl/crc16_pkg.sv
// CRC-CCITT-16 shared constants, FSM state type and a reference step.
// Used by the frame checker and available to benches and decoders.
package crc16_pkg;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic [15:0] data
  );
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = (c << 1) ^ CRC16_CCITT_POLY;
      else c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_frame_checker_ctrl_if.sv
// Word stream in, frame result out, for the CRC frame checker.
// master drives words and result-ready; slave is the checker.
interface crc16_frame_checker_ctrl_if #(
  parameter int LEN_W = 7
);
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic             m_pass;
  logic             m_err_len;
  logic [LEN_W-1:0] m_len;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_pass, m_err_len, m_len
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_pass, m_err_len, m_len
  );
endinterface

// File: rtl/crc16_word_step.sv
// Combinational CRC update: folds one 16-bit word MSB-first.
// Shared with the word/CRC decoder.
module crc16_word_step
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_CCITT_POLY
) (
  input  logic [15:0] crc_in,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // sixteen serial shifts unrolled into one cycle
  always_comb begin
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data_in[i]) c = (c << 1) ^ POLY;
      else c = c << 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc16_frame_checker_ctrl.sv
// Frame-level CRC-CCITT-16 checker: folds every word incl. the CRC,
// reports pass/fail per frame and keeps saturating good/bad counts.
module crc16_frame_checker_ctrl
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY      = CRC16_CCITT_POLY,
  parameter logic [15:0] INIT      = CRC16_CCITT_INIT,
  parameter int          MAX_WORDS = 64,
  parameter int          LEN_W     = 7,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr,
  crc16_frame_checker_ctrl_if.slave bus,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

  state_t           state;
  state_t           state_nxt;
  logic             ready_en;
  logic [15:0]      crc_q;
  logic [15:0]      crc_nxt;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;
  logic             s_hs;
  logic             m_hs;
  logic             pass_q;
  logic             err_q;
  logic [LEN_W-1:0] len_q;
  logic             bad_len;

  crc16_word_step #(.POLY(POLY)) u_step (
    .crc_in  (crc_q),
    .data_in (bus.s_data),
    .crc_out (crc_nxt)
  );

  assign bus.s_ready = ready_en && (state != REPORT);
  assign bus.m_valid = (state == REPORT);
  assign bus.m_pass    = pass_q;
  assign bus.m_err_len = err_q;
  assign bus.m_len     = len_q;

  assign s_hs = bus.s_valid && bus.s_ready;
  assign m_hs = bus.m_valid && bus.m_ready;

  assign cnt_inc = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 1'b1;
  assign bad_len = (state == DRAIN) || (cnt_inc < LEN_MIN)
                || (cnt_inc > LEN_MAX);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: frame sequencing, abort has top priority
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (s_hs) begin
          if (bus.s_last)          state_nxt = REPORT;
          else if (cnt_inc == LEN_MAX) state_nxt = DRAIN;
          else                     state_nxt = ACCUM;
        end
      end
      DRAIN: begin
        if (s_hs && bus.s_last) state_nxt = REPORT;
      end
      REPORT: begin
        if (bus.m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (soft_clr) state_nxt = IDLE;
  end

  // hold s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // running CRC, word count and registered frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q  <= INIT;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
      len_q  <= '0;
    end else if (soft_clr) begin
      crc_q  <= INIT;
      cnt_q  <= '0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
      len_q  <= '0;
    end else if (m_hs) begin
      crc_q <= INIT;
      cnt_q <= '0;
    end else if (s_hs) begin
      cnt_q <= cnt_inc;
      if (state != DRAIN) crc_q <= crc_nxt;
      if (bus.s_last) begin
        len_q  <= cnt_inc;
        err_q  <= bad_len;
        pass_q <= !bad_len && (crc_nxt == 16'h0000);
      end
    end
  end

  // saturating good/bad frame counters, bumped on result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      bad_cnt <= '0;
    end else if (soft_clr) begin
      ok_cnt  <= '0;
      bad_cnt <= '0;
    end else if (m_hs) begin
      if (pass_q) begin
        if (ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
      end else begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc16_frame_checker_ctrl.sv
// Scoreboard bench for the CRC frame checker: directed frames plus
// random frames checked against a frame-level reference model.
module tb_crc16_frame_checker_ctrl;

  localparam int MAXW  = 64;
  localparam int LEN_W = 7;
  localparam int CNT_W = 16;

  typedef struct {
    logic pass;
    logic err;
    int   len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic soft_clr;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] bad_cnt;

  crc16_frame_checker_ctrl_if #(.LEN_W(LEN_W)) bus_if ();

  crc16_frame_checker_ctrl #(
    .MAX_WORDS (MAXW),
    .LEN_W     (LEN_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_clr (soft_clr),
    .bus      (bus_if),
    .ok_cnt   (ok_cnt),
    .bad_cnt  (bad_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  int   exp_ok  = 0;
  int   exp_bad = 0;
  int   mr_mode = 1;
  bit   gaps    = 0;
  logic [15:0] frm[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // CRC of one word: xor into register, then divide 16 bit-times
  function automatic logic [15:0] ref_crc(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    r = c ^ d;
    repeat (16) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // frame-level model of the result
  function automatic exp_t model(input logic [15:0] w[$]);
    exp_t e;
    logic [15:0] c;
    int n;
    n = w.size();
    c = 16'hFFFF;
    for (int i = 0; i < n && i < MAXW; i++) c = ref_crc(c, w[i]);
    e.len  = (n > MAXW + 1) ? MAXW + 1 : n;
    e.err  = (n < 2) || (n > MAXW);
    e.pass = !e.err && (c == 16'h0000);
    return e;
  endfunction

  // result-side ready: 0 random, 1 always, 2 held low
  initial begin
    bus_if.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       bus_if.m_ready = ($urandom % 3) != 0;
        1:       bus_if.m_ready = 1'b1;
        default: bus_if.m_ready = 1'b0;
      endcase
    end
  end

  // monitor: latency, result fields and counters on each handshake
  bit last_hs = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_hs = 0;
    end else begin
      if (last_hs) chk("latency_m_valid", bus_if.m_valid, 1);
      last_hs = bus_if.s_valid && bus_if.s_ready
             && bus_if.s_last && !soft_clr;
      if (bus_if.m_valid && bus_if.m_ready && !soft_clr) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("m_pass", bus_if.m_pass, e.pass);
          chk("m_err_len", bus_if.m_err_len, e.err);
          chk("m_len", bus_if.m_len, e.len);
          chk("ok_cnt_pre", ok_cnt, exp_ok);
          chk("bad_cnt_pre", bad_cnt, exp_bad);
          if (e.pass) exp_ok++;
          else exp_bad++;
        end
      end
    end
  end

  task automatic send_frame(input bit with_last);
    int k;
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps && ($urandom % 4) == 0) begin
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 16'($urandom);
        @(posedge clk);
        #1;
      end
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = frm[i];
      bus_if.s_last  = with_last && (i == frm.size() - 1);
      k = 0;
      forever begin
        bit acc;
        @(negedge clk);
        acc = bus_if.s_ready;
        @(posedge clk);
        #1;
        k++;
        if (acc || k > 400) break;
      end
      if (k > 400) chk("s_ready_timeout", k, 0);
    end
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
  endtask

  task automatic issue(input bit with_last);
    if (with_last) sb_q.push_back(model(frm));
    send_frame(with_last);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus_if.m_valid) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", k < 600, 1);
  endtask

  task automatic wait_mvalid();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.m_valid && k < 400);
    chk("m_valid_seen", bus_if.m_valid, 1);
  endtask

  task automatic rand_frame();
    int n;
    int r;
    logic [15:0] c;
    r = $urandom % 10;
    if (r == 0)      n = 1;
    else if (r == 1) n = 60 + $urandom % 10;
    else             n = 2 + $urandom % 10;
    frm.delete();
    c = 16'hFFFF;
    for (int i = 0; i < n - 1; i++) begin
      frm.push_back(16'($urandom));
      c = ref_crc(c, frm[i]);
    end
    if (($urandom % 3) != 0) frm.push_back(c);
    else frm.push_back(16'($urandom));
  endtask

  initial begin
    int nb;
    rst_n = 1'b0;
    soft_clr = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_last  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_s_ready", bus_if.s_ready, 0);
    chk("rst_m_valid", bus_if.m_valid, 0);
    chk("rst_m_pass", bus_if.m_pass, 0);
    chk("rst_m_err_len", bus_if.m_err_len, 0);
    chk("rst_m_len", bus_if.m_len, 0);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", bus_if.s_ready, 1);
    @(posedge clk);
    #1;

    // minimal pass under 10 cycles of backpressure
    mr_mode = 2;
    frm = '{16'hFFFE, 16'h1021};
    issue(1);
    wait_mvalid();
    repeat (10) begin
      @(negedge clk);
      chk("bp_m_valid", bus_if.m_valid, 1);
      chk("bp_s_ready", bus_if.s_ready, 0);
      chk("bp_m_pass", bus_if.m_pass, 1);
      chk("bp_m_len", bus_if.m_len, 2);
      chk("bp_ok_cnt", ok_cnt, 0);
    end
    mr_mode = 1;
    wait_idle();
    @(negedge clk);
    chk("ok_after_min", ok_cnt, 1);

    // back-to-back frames, one bubble between them
    @(posedge clk);
    #1;
    frm = '{16'hFFFF, 16'h0001, 16'h1021};
    issue(1);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus_if.s_ready) nb++;
      else break;
    end
    chk("bubble_cycles", nb, 1);
    @(posedge clk);
    #1;
    frm = '{16'hFFFF, 16'h0000, 16'h0000};
    issue(1);
    wait_idle();
    @(negedge clk);
    chk("ok_after_b2b", ok_cnt, 3);

    // corrupt CRC, single word, length limits
    @(posedge clk);
    #1;
    gaps = 1;
    mr_mode = 0;
    frm = '{16'hFFFE, 16'h1020};
    issue(1);
    frm = '{16'hFFFF};
    issue(1);
    frm.delete();
    for (int i = 0; i < 70; i++) frm.push_back(16'(i * 7));
    issue(1);
    begin
      logic [15:0] c;
      frm.delete();
      c = 16'hFFFF;
      for (int i = 0; i < MAXW - 1; i++) begin
        frm.push_back(16'($urandom));
        c = ref_crc(c, frm[i]);
      end
      frm.push_back(c);
    end
    issue(1);
    wait_idle();
    @(negedge clk);
    chk("ok_after_dir", ok_cnt, 4);
    chk("bad_after_dir", bad_cnt, 3);

    // soft_clr mid-frame
    @(posedge clk);
    #1;
    mr_mode = 1;
    gaps = 0;
    frm = '{16'h1234, 16'h5678, 16'h9ABC};
    send_frame(0);
    soft_clr = 1'b1;
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
    exp_ok = 0;
    exp_bad = 0;
    @(negedge clk);
    chk("clr_ok_cnt", ok_cnt, 0);
    chk("clr_bad_cnt", bad_cnt, 0);
    chk("clr_m_valid", bus_if.m_valid, 0);
    chk("clr_s_ready", bus_if.s_ready, 1);
    @(posedge clk);
    #1;
    frm = '{16'hFFFE, 16'h1021};
    issue(1);
    wait_idle();
    @(negedge clk);
    chk("ok_after_clr", ok_cnt, 1);

    // soft_clr coincident with result handshake
    @(posedge clk);
    #1;
    mr_mode = 2;
    frm = '{16'hFFFE, 16'h1021};
    issue(1);
    wait_mvalid();
    mr_mode = 1;
    @(posedge clk);
    #1;
    soft_clr = 1'b1;
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
    sb_q.delete();
    exp_ok = 0;
    exp_bad = 0;
    @(negedge clk);
    chk("clr_hs_ok_cnt", ok_cnt, 0);
    chk("clr_hs_m_valid", bus_if.m_valid, 0);

    // random frames
    @(posedge clk);
    #1;
    gaps = 1;
    for (int f = 0; f < 40; f++) begin
      mr_mode = $urandom % 2;
      rand_frame();
      issue(1);
    end
    mr_mode = 1;
    wait_idle();
    @(negedge clk);
    chk("ok_after_rand", ok_cnt, exp_ok);
    chk("bad_after_rand", bad_cnt, exp_bad);

    // async reset while a result is pending
    @(posedge clk);
    #1;
    mr_mode = 2;
    gaps = 0;
    frm = '{16'hFFFE, 16'h1021};
    issue(1);
    wait_mvalid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", bus_if.m_valid, 0);
    chk("arst_s_ready", bus_if.s_ready, 0);
    chk("arst_m_pass", bus_if.m_pass, 0);
    chk("arst_m_len", bus_if.m_len, 0);
    chk("arst_ok_cnt", ok_cnt, 0);
    chk("arst_bad_cnt", bad_cnt, 0);
    sb_q.delete();
    exp_ok = 0;
    exp_bad = 0;
    mr_mode = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_m_valid", bus_if.m_valid, 0);
    chk("post_rst_s_ready", bus_if.s_ready, 1);
    @(posedge clk);
    #1;
    frm = '{16'hFFFF, 16'h0001, 16'h1021};
    issue(1);
    wait_idle();
    @(negedge clk);
    chk("final_ok_cnt", ok_cnt, 1);
    chk("final_bad_cnt", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
